// File: rtl/dlsc_uart_rx_buffer.sv
// Receive buffer behind the UART rx core: FWFT FIFO with ready/valid read side,
// hysteretic RTS flow control and saturating drop/error statistics.
module dlsc_uart_rx_buffer #(
  parameter int DATA        = 8,
  parameter int ADDR        = 4,
  parameter int RTS_OFF     = 12,
  parameter int RTS_ON      = 4,
  parameter int DROP_ERRORS = 0,
  parameter int CNT_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA-1:0]     in_data,
  input  logic                in_frame_error,
  input  logic                in_parity_error,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA-1:0]     out_data,
  output logic                out_frame_error,
  output logic                out_parity_error,
  output logic [ADDR:0]       count,
  output logic                full,
  output logic                rts,
  output logic                overflow,
  input  logic                clear_stats,
  output logic [CNT_BITS-1:0] overflow_cnt,
  output logic [CNT_BITS-1:0] frame_err_cnt,
  output logic [CNT_BITS-1:0] parity_err_cnt
);
  localparam int DEPTH = 1 << ADDR;
  localparam int W     = DATA + 2;
  localparam logic [ADDR:0] DEPTH_C   = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] RTS_OFF_C = (ADDR+1)'(RTS_OFF);
  localparam logic [ADDR:0] RTS_ON_C  = (ADDR+1)'(RTS_ON);

  logic [W-1:0]  mem [DEPTH];
  logic [ADDR:0] wr_ptr, rd_ptr, next_count;
  logic [W-1:0]  head;
  logic          err_drop, push, pop, ovf_drop;

  // Entries discarded for framing never reach the FIFO and are not overflows.
  assign err_drop   = (DROP_ERRORS != 0) && in_frame_error;
  assign full       = (count == DEPTH_C);
  assign out_valid  = (count != '0);
  assign push       = in_valid && !full && !err_drop;
  assign pop        = out_valid && out_ready;
  assign ovf_drop   = in_valid && full && !err_drop;
  assign next_count = count + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, pop};

  assign head             = mem[rd_ptr[ADDR-1:0]];
  assign out_data         = out_valid ? head[DATA-1:0] : '0;
  assign out_parity_error = out_valid & head[DATA];
  assign out_frame_error  = out_valid & head[DATA+1];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR-1:0]] <= {in_frame_error, in_parity_error, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rts    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
      // Hysteresis evaluated on the post-update occupancy.
      if (rts && next_count >= RTS_OFF_C)      rts <= 1'b0;
      else if (!rts && next_count <= RTS_ON_C) rts <= 1'b1;
    end
  end

  // Clear has priority over any same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      overflow       <= 1'b0;
      overflow_cnt   <= '0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
    end else begin
      if (ovf_drop) begin
        overflow <= 1'b1;
        if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
      end
      if (in_valid && in_frame_error && frame_err_cnt != '1)
        frame_err_cnt <= frame_err_cnt + 1'b1;
      if (in_valid && in_parity_error && parity_err_cnt != '1)
        parity_err_cnt <= parity_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dlsc_uart_rx_buffer.sv
// Scoreboard bench for dlsc_uart_rx_buffer: a queue model for the default build,
// plus a DROP_ERRORS=1 instance exercised directly.
module tb_dlsc_uart_rx_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_fe, in_pe, out_ready, clear_stats;
  logic [7:0] in_data;
  logic out_valid, out_fe, out_pe, full, rts, overflow;
  logic [7:0] out_data, ovf_cnt, fe_cnt, pe_cnt;
  logic [4:0] count;

  logic de_valid, de_ready;
  logic de_out_valid, de_fe, de_pe, de_full, de_rts, de_ovf;
  logic [7:0] de_data, de_ovf_cnt, de_fe_cnt, de_pe_cnt;
  logic [4:0] de_count;

  dlsc_uart_rx_buffer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_frame_error(in_fe), .in_parity_error(in_pe), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_frame_error(out_fe),
    .out_parity_error(out_pe), .count(count), .full(full), .rts(rts),
    .overflow(overflow), .clear_stats(clear_stats), .overflow_cnt(ovf_cnt),
    .frame_err_cnt(fe_cnt), .parity_err_cnt(pe_cnt)
  );

  dlsc_uart_rx_buffer #(.DROP_ERRORS(1)) u_dut_de (
    .clk(clk), .rst(rst), .in_valid(de_valid), .in_data(in_data),
    .in_frame_error(in_fe), .in_parity_error(in_pe), .out_ready(de_ready),
    .out_valid(de_out_valid), .out_data(de_data), .out_frame_error(de_fe),
    .out_parity_error(de_pe), .count(de_count), .full(de_full), .rts(de_rts),
    .overflow(de_ovf), .clear_stats(1'b0), .overflow_cnt(de_ovf_cnt),
    .frame_err_cnt(de_fe_cnt), .parity_err_cnt(de_pe_cnt)
  );

  int n_vec = 0, n_err = 0;
  logic [9:0] q[$];
  logic m_rts, m_ovf;
  int m_ovf_cnt, m_fe_cnt, m_pe_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Called at negedge with inputs already applied; advances model and DUT one cycle.
  task automatic tick();
    logic push, pop;
    logic [9:0] exp;
    int nc;
    push = in_valid && (q.size() < 16);
    pop  = out_ready && (q.size() != 0);
    if (pop) begin
      exp = q.pop_front();
      chk("pop_data", {22'd0, out_fe, out_pe, out_data}, {22'd0, exp});
    end
    if (push) q.push_back({in_fe, in_pe, in_data});
    if (clear_stats) begin
      m_ovf = 1'b0; m_ovf_cnt = 0; m_fe_cnt = 0; m_pe_cnt = 0;
    end else if (in_valid) begin
      if (!push) begin m_ovf = 1'b1; m_ovf_cnt = sat(m_ovf_cnt); end
      if (in_fe) m_fe_cnt = sat(m_fe_cnt);
      if (in_pe) m_pe_cnt = sat(m_pe_cnt);
    end
    nc = q.size();
    if (m_rts && nc >= 12)      m_rts = 1'b0;
    else if (!m_rts && nc <= 4) m_rts = 1'b1;
    @(posedge clk); #1;
    chk("count", count, nc);
    chk("rts", rts, m_rts);
    chk("out_valid", out_valid, nc != 0);
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_ovf_cnt"}, ovf_cnt, m_ovf_cnt);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_fe_cnt"}, fe_cnt, m_fe_cnt);
    chk({tag, "_pe_cnt"}, pe_cnt, m_pe_cnt);
    chk({tag, "_full"}, full, q.size() == 16);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fe = 1'b0; in_pe = 1'b0; in_data = '0;
    out_ready = 1'b0; clear_stats = 1'b0; de_valid = 1'b0; de_ready = 1'b0;
    m_rts = 1'b1; m_ovf = 1'b0; m_ovf_cnt = 0; m_fe_cnt = 0; m_pe_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rts", rts, 1);
    chk_stats("rst");

    // Single byte: visible the cycle after the push.
    in_valid = 1'b1; in_data = 8'hA5; tick();
    in_valid = 1'b0;
    chk("t1_data", out_data, 8'hA5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill, overflow by three, drain in order (rts crosses 12 and 4 on the way).
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin in_data = 8'(i); tick(); end
    for (int i = 0; i < 3; i++)  begin in_data = 8'(8'hF0 + i); tick(); end
    chk("t2_ovf_cnt3", ovf_cnt, 3);
    chk_stats("t2");
    drain();

    // Full with a same-cycle pop: push still dropped.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin in_data = 8'(8'h40 + i); tick(); end
    out_ready = 1'b1; in_data = 8'hEE; tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t3_count", count, 15);
    chk_stats("t3");
    drain();

    // Error flags travel with data and are counted.
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    chk_stats("clr");
    in_valid = 1'b1;
    in_data = 8'h31; in_fe = 1'b1; tick();
    in_data = 8'h32; in_fe = 1'b0; in_pe = 1'b1; tick();
    in_data = 8'h33; in_fe = 1'b1; tick();
    in_fe = 1'b0; in_pe = 1'b0; in_valid = 1'b0;
    chk_stats("flags");
    drain();

    // Saturation, then clear racing an overflow.
    in_valid = 1'b1;
    for (int i = 0; i < 16 + 300; i++) begin in_data = 8'(i); tick(); end
    chk("t6_sat", ovf_cnt, 255);
    chk_stats("t6");
    clear_stats = 1'b1; tick(); clear_stats = 1'b0; in_valid = 1'b0;
    chk("t6_clr_cnt", ovf_cnt, 0);
    chk("t6_clr_ovf", overflow, 0);
    chk("t6_keep", count, 16);
    drain();

    // DROP_ERRORS instance: frame-error byte counted but not stored.
    de_valid = 1'b1; in_data = 8'h11; in_fe = 1'b1; tick();
    in_data = 8'h22; in_fe = 1'b0; in_pe = 1'b1; tick();
    de_valid = 1'b0; in_pe = 1'b0;
    chk("de_count", de_count, 1);
    chk("de_data", de_data, 8'h22);
    chk("de_pe", de_pe, 1);
    chk("de_fe", de_fe, 0);
    chk("de_fe_cnt", de_fe_cnt, 1);
    chk("de_pe_cnt", de_pe_cnt, 1);
    chk("de_ovf", de_ovf, 0);

    // Reset mid-stream empties the FIFO.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 8'(i); tick(); end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rts", rts, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got hung expected finish");
    $fatal(1);
  end
endmodule
